alt_seq_gen: RTL and testbench
==============================

// Module: alt_seq_gen
// PURPOSE
//  Serial transmitter for the alternating-sequence checker link. Emits a programmed-length
//  bit stream on one wire, each bit held HOLD clocks, consecutive bits alternating.
//  Optional injection of one repeated bit at a chosen index for negative testing.
//  Reports the pass/fail verdict the receiving checker must produce.
// PARAMETERS
//  LEN_W  8  width of len / inj_idx; max sequence length 2**LEN_W-1 bits
//  HOLD   2  clocks each bit is held on ser_out (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request a transmission; sampled only in IDLE
//  len        in   LEN_W  number of bits to send, captured with start
//  first_bit  in   1      value of bit 0, captured with start
//  inj_en     in   1      enable single-error injection, captured with start
//  inj_idx    in   LEN_W  bit index that repeats its predecessor, captured with start
//  ser_out    out  1      serial data to checker
//  bit_valid  out  1      high in the first cycle of each bit (checker sample phase)
//  busy       out  1      high while bits are being driven
//  done       out  1      1-cycle pulse at end of transmission
//  expect_ok  out  1      verdict the checker must give for the last sequence
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-transmission): state=IDLE, ser_out=0, bit_valid=0,
//    busy=0, done=0, expect_ok=1, bit and hold counters=0. Partial sequence abandoned.
//  - States: IDLE -> SEND -> DONE -> IDLE.
//    IDLE: start=1 and len!=0 at edge T -> latch inputs, go to SEND.
//          start=1 and len==0 -> go to DONE directly, no bits sent, expect_ok=1.
//    SEND: bit k driven for HOLD cycles; after bit len-1 final hold cycle -> DONE.
//    DONE: done=1 for exactly one cycle, then IDLE. start ignored in SEND and DONE.
//  - Timing: bit 0 on ser_out at cycle T+1; bit k occupies cycles T+1+k*HOLD ..
//    T+(k+1)*HOLD. busy high exactly those cycles; done high at cycle T+1+len*HOLD.
//  - bit_valid=1 in cycle T+1+k*HOLD, else 0 (including IDLE/DONE).
//  - Bit value: b0=first_bit; bk=~b(k-1) for k>=1, except bk=b(k-1) when latched
//    inj_en=1 and k==inj_idx.
//  - Injection active only if inj_en=1 and 1<=inj_idx<=len-1; otherwise no error inserted.
//  - expect_ok: updated at the DONE cycle = ~(injection active); holds until next accepted
//    start, where it returns to 1 at T+1. Single-bit sequence (len=1) always expect_ok=1.
//  - ser_out in IDLE/DONE holds the last driven bit (0 after reset).
//  - Hold counter LEN_W-independent, width clog2(HOLD)+1; bit counter LEN_W bits,
//    never wraps (stops at len-1).
//  - Input changes while busy have no effect on the running sequence.
// TESTING
//  1 rst, start len=4 first_bit=1 inj_en=0 -> ser_out 1,1,0,0,1,1,0,0 from T+1;
//    bit_valid at T+1,3,5,7; done at T+9; expect_ok=1.
//  2 len=5 first_bit=0 inj_en=1 inj_idx=2 -> bits 0,1,1,0,1; done at T+11; expect_ok=0.
//  3 inj_en=1 inj_idx=0 and inj_idx=len (len=3) -> bits alternate, expect_ok=1.
//  4 start len=0 -> done at T+1, busy never high, ser_out unchanged, expect_ok=1.
//  5 start pulsed again at T+3 of a len=4 run, len/first_bit changed -> ignored, run unchanged.
//  6 assert rst at T+4 of a len=6 run -> all outputs to reset values same cycle;
//    new start after rst release sends full fresh sequence.
//  Bench also connects ser_out to the checker (sampling every 2nd clock, HOLD=2) and
//    compares its output against expect_ok on done.

Source files
------------

// File: rtl/alt_seq_gen.sv
// alt_seq_gen: serial alternating-bit sequence transmitter.
// Sends len bits on ser_out, each bit held HOLD clocks, consecutive bits
// alternating, with optional single repeated bit at inj_idx. expect_ok
// reports the verdict a downstream alternation checker must produce.
module alt_seq_gen #(
    parameter int LEN_W = 8,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             first_bit,
    input  logic             inj_en,
    input  logic [LEN_W-1:0] inj_idx,
    output logic             ser_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             expect_ok
);

    // Hold counter only needs to reach HOLD-1; one spare bit keeps HOLD=1 legal.
    localparam int HCW = $clog2(HOLD) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] idx_reg;
    logic             inj_act_reg;
    logic [LEN_W-1:0] bit_cnt_reg;
    logic [HCW-1:0]   hold_cnt_reg;

    logic             inj_act_next;
    logic             last_hold;
    logic             last_bit;
    logic             next_bit;

    // Decode whether the requested injection lands inside the sequence and
    // what the next bit to drive is (repeat at the injected index, else toggle).
    always_comb begin
        inj_act_next = inj_en && (inj_idx != '0) && (inj_idx < len);
        last_hold    = (hold_cnt_reg == HCW'(HOLD - 1));
        last_bit     = (bit_cnt_reg == (len_reg - LEN_W'(1)));
        next_bit     = ~ser_out;
        if (inj_act_reg && ((bit_cnt_reg + LEN_W'(1)) == idx_reg)) begin
            next_bit = ser_out;
        end
    end

    // Transmit FSM with registered outputs; start is only honoured in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            idx_reg      <= '0;
            inj_act_reg  <= 1'b0;
            bit_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            ser_out      <= 1'b0;
            bit_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            expect_ok    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    done      <= 1'b0;
                    bit_valid <= 1'b0;
                    if (start) begin
                        expect_ok <= 1'b1;
                        if (len != '0) begin
                            state_reg    <= SEND;
                            len_reg      <= len;
                            idx_reg      <= inj_idx;
                            inj_act_reg  <= inj_act_next;
                            bit_cnt_reg  <= '0;
                            hold_cnt_reg <= '0;
                            ser_out      <= first_bit;
                            bit_valid    <= 1'b1;
                            busy         <= 1'b1;
                        end else begin
                            // Empty sequence: nothing to send, trivially passes.
                            state_reg   <= DONE;
                            inj_act_reg <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (last_hold) begin
                        hold_cnt_reg <= '0;
                        if (last_bit) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            bit_valid <= 1'b0;
                            done      <= 1'b1;
                            expect_ok <= ~inj_act_reg;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + LEN_W'(1);
                            ser_out     <= next_bit;
                            bit_valid   <= 1'b1;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HCW'(1);
                        bit_valid    <= 1'b0;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alt_seq_gen.sv
// tb_alt_seq_gen: randomized bench for alt_seq_gen with a closed-form
// reference model, a per-cycle compare process, an alternation checker
// fed from ser_out, and literal expectations for the directed cases.
module tb_alt_seq_gen;

    localparam int LEN_W = 8;
    localparam int HOLD  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             first_bit = 1'b0;
    logic             inj_en = 1'b0;
    logic [LEN_W-1:0] inj_idx = '0;
    logic             ser_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             expect_ok;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alt_seq_gen #(.LEN_W(LEN_W), .HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .first_bit (first_bit),
        .inj_en    (inj_en),
        .inj_idx   (inj_idx),
        .ser_out   (ser_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .expect_ok (expect_ok)
    );

    // ---------------- reference model ----------------
    // A transaction is described by the cycle offset r since its accepting
    // edge (r=0 is the first cycle after it); every output follows from r.
    int   m_r   = 0;
    bit   m_has = 1'b0;
    int   m_len = 0;
    bit   m_fb  = 1'b0;
    bit   m_inj = 1'b0;
    int   m_idx = 0;
    logic e_ser = 1'b0, e_bv = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ok = 1'b1;

    // Value of bit k: alternate from fb; past an active injection the
    // parity shifts by one because bit idx repeats bit idx-1.
    function automatic logic model_bit(bit fb, bit inj, int idx, int k);
        if (k == 0) return fb;
        if (inj && k >= idx) return fb ^ bit'((k - 1) & 1);
        return fb ^ bit'(k & 1);
    endfunction

    always @(posedge clk or posedge rst) begin : model_blk
        int   r_n;
        bit   has_n;
        int   len_n;
        bit   fb_n;
        bit   inj_n;
        int   idx_n;
        logic ok_n;
        logic ser_n;
        logic bv_n;
        logic busy_n;
        logic done_n;
        if (rst) begin
            m_has  <= 1'b0;
            m_r    <= 0;
            e_ser  <= 1'b0;
            e_bv   <= 1'b0;
            e_busy <= 1'b0;
            e_done <= 1'b0;
            e_ok   <= 1'b1;
        end else begin
            r_n = m_r; has_n = m_has; len_n = m_len; fb_n = m_fb;
            inj_n = m_inj; idx_n = m_idx; ok_n = e_ok; ser_n = e_ser;
            if ((!has_n || r_n > len_n * HOLD) && start === 1'b1) begin
                has_n = 1'b1;
                r_n   = 0;
                len_n = int'(len);
                fb_n  = first_bit;
                idx_n = int'(inj_idx);
                inj_n = inj_en && (idx_n >= 1) && (idx_n <= len_n - 1);
                ok_n  = 1'b1;
            end else if (has_n) begin
                r_n++;
            end
            busy_n = 1'b0;
            bv_n   = 1'b0;
            if (has_n && r_n < len_n * HOLD) begin
                busy_n = 1'b1;
                bv_n   = ((r_n % HOLD) == 0);
                ser_n  = model_bit(fb_n, inj_n, idx_n, r_n / HOLD);
            end
            done_n = has_n && (r_n == len_n * HOLD);
            if (done_n) ok_n = !inj_n;
            m_r <= r_n; m_has <= has_n; m_len <= len_n; m_fb <= fb_n;
            m_inj <= inj_n; m_idx <= idx_n;
            e_ser <= ser_n; e_bv <= bv_n; e_busy <= busy_n; e_done <= done_n; e_ok <= ok_n;
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Receiver-side alternation checker state (samples every 2nd clock).
    bit   c_in = 1'b0, c_err = 1'b0, c_first = 1'b1;
    logic c_prev = 1'b0;
    int   c_phase = 0;

    task automatic check_cycle();
        chk_bit("ser_out",   ser_out,   e_ser);
        chk_bit("bit_valid", bit_valid, e_bv);
        chk_bit("busy",      busy,      e_busy);
        chk_bit("done",      done,      e_done);
        chk_bit("expect_ok", expect_ok, e_ok);
        if (rst) begin
            c_in  = 1'b0;
            c_err = 1'b0;
        end else begin
            if (busy) begin
                if (!c_in) begin
                    c_in = 1'b1; c_phase = 0; c_err = 1'b0; c_first = 1'b1;
                end
                if ((c_phase % 2) == 0) begin
                    if (!c_first && ser_out == c_prev) c_err = 1'b1;
                    c_prev  = ser_out;
                    c_first = 1'b0;
                end
                c_phase++;
            end else begin
                c_in = 1'b0;
            end
            if (done) begin
                chk_bit("checker_verdict", expect_ok, !c_err);
                c_err = 1'b0;
            end
        end
    endtask

    // Runs one transaction. glitch_at: cycle to re-pulse start with other
    // inputs (0 = none). rst_at: cycle to assert reset mid-run (0 = none).
    task automatic run_txn(input int l, input bit fb, input bit en, input int idx,
                           input int glitch_at, input int rst_at,
                           output logic [31:0] bits, output int nbits,
                           output int cycles, output logic ok_at_done);
        bit done_seen;
        bits = '0; nbits = 0; cycles = 0; ok_at_done = 1'bx; done_seen = 1'b0;
        @(posedge clk); #2;
        len = LEN_W'(l); first_bit = fb; inj_en = en; inj_idx = LEN_W'(idx); start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        len = LEN_W'($urandom); first_bit = ~fb; inj_en = ~en; inj_idx = LEN_W'($urandom);
        while (!done_seen && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (bit_valid) begin
                bits = {bits[30:0], ser_out};
                nbits++;
            end
            if (done) begin
                done_seen  = 1'b1;
                ok_at_done = expect_ok;
            end
            if (glitch_at != 0 && cycles == glitch_at) begin
                start = 1'b1; len = LEN_W'(l + 3); first_bit = ~fb;
            end else begin
                start = 1'b0;
            end
            if (rst_at != 0 && cycles == rst_at) begin
                #1 rst = 1'b1;
                #1;
                chk_bit("rst_ser_out",   ser_out,   1'b0);
                chk_bit("rst_bit_valid", bit_valid, 1'b0);
                chk_bit("rst_busy",      busy,      1'b0);
                chk_bit("rst_done",      done,      1'b0);
                chk_bit("rst_expect_ok", expect_ok, 1'b1);
                @(posedge clk); #2;
                rst = 1'b0;
                return;
            end
        end
        if (!done_seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no done within %0d cycles (len=%0d)", cycles, l);
        end
        $display("txn len=%0d fb=%0d inj_en=%0d idx=%0d -> bits=%0d cycles=%0d ok=%b",
                 l, fb, en, idx, nbits, cycles, ok_at_done);
    endtask

    logic [31:0] bits;
    int          nbits, cycles;
    logic        ok;

    initial begin
        fork
            forever begin
                @(negedge clk);
                check_cycle();
            end
        join_none

        #1 rst = 1'b1;
        #1;
        chk_bit("reset_ser_out",   ser_out,   1'b0);
        chk_bit("reset_bit_valid", bit_valid, 1'b0);
        chk_bit("reset_busy",      busy,      1'b0);
        chk_bit("reset_done",      done,      1'b0);
        chk_bit("reset_expect_ok", expect_ok, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // plain alternation, first bit 1
        run_txn(4, 1'b1, 1'b0, 0, 0, 0, bits, nbits, cycles, ok);
        chk_int("t1_bits", int'(bits), 'b1010);
        chk_int("t1_nbits", nbits, 4);
        chk_int("t1_done_cycle", cycles, 9);
        chk_bit("t1_ok", ok, 1'b1);

        // injection at index 2
        run_txn(5, 1'b0, 1'b1, 2, 0, 0, bits, nbits, cycles, ok);
        chk_int("t2_bits", int'(bits), 'b01101);
        chk_int("t2_done_cycle", cycles, 11);
        chk_bit("t2_ok", ok, 1'b0);

        // out-of-range injection indices
        run_txn(3, 1'b1, 1'b1, 0, 0, 0, bits, nbits, cycles, ok);
        chk_int("t3a_bits", int'(bits), 'b101);
        chk_bit("t3a_ok", ok, 1'b1);
        run_txn(3, 1'b1, 1'b1, 3, 0, 0, bits, nbits, cycles, ok);
        chk_int("t3b_bits", int'(bits), 'b101);
        chk_bit("t3b_ok", ok, 1'b1);

        // zero-length request
        run_txn(0, 1'b0, 1'b1, 1, 0, 0, bits, nbits, cycles, ok);
        chk_int("t4_nbits", nbits, 0);
        chk_int("t4_done_cycle", cycles, 1);
        chk_bit("t4_ok", ok, 1'b1);

        // start re-pulsed while busy must be ignored
        run_txn(4, 1'b0, 1'b0, 0, 2, 0, bits, nbits, cycles, ok);
        chk_int("t5_bits", int'(bits), 'b0101);
        chk_int("t5_done_cycle", cycles, 9);

        // reset mid-transmission, then a fresh full run
        run_txn(6, 1'b0, 1'b1, 3, 0, 4, bits, nbits, cycles, ok);
        run_txn(6, 1'b0, 1'b0, 0, 0, 0, bits, nbits, cycles, ok);
        chk_int("t6_bits", int'(bits), 'b010101);
        chk_int("t6_done_cycle", cycles, 13);
        chk_bit("t6_ok", ok, 1'b1);

        // single-bit sequence, injection requested
        run_txn(1, 1'b1, 1'b1, 1, 0, 0, bits, nbits, cycles, ok);
        chk_int("len1_bits", int'(bits), 1);
        chk_bit("len1_ok", ok, 1'b1);

        // maximum length with injection at the last bit
        run_txn(255, 1'b1, 1'b1, 254, 0, 0, bits, nbits, cycles, ok);
        chk_int("max_nbits", nbits, 255);
        chk_int("max_done_cycle", cycles, 511);
        chk_bit("max_ok", ok, 1'b0);

        // randomized transactions (model + checker compare every cycle)
        for (int i = 0; i < 40; i++) begin
            int l;
            int idx;
            l   = $urandom_range(0, 12);
            idx = $urandom_range(0, l + 1);
            run_txn(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), idx,
                    $urandom_range(0, 5), 0, bits, nbits, cycles, ok);
            chk_int("rnd_nbits", nbits, l);
            chk_int("rnd_done_cycle", cycles, l * HOLD + 1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
